// File: rtl/grid_input_buffer.sv
// Commit-gated first-word-fall-through ingress FIFO feeding the west input of grid core 0.
// Define GRID_INPUT_BUFFER_COMMIT_EN to enable commit gating; without it this is a plain FWFT FIFO.
module grid_input_buffer #(
    parameter int PACKET_WIDTH = 30,
    parameter int DEPTH        = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [PACKET_WIDTH-1:0]   wr_data,
    input  logic                      commit,
    output logic                      full,
    input  logic                      ren,
    output logic                      empty,
    output logic [PACKET_WIDTH-1:0]   packet_out,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow_error,
    output logic                      underflow_error
);

    localparam int AW = $clog2(DEPTH);

    logic [PACKET_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]             wr_ptr;
    logic [AW:0]             rd_ptr;
    logic [AW:0]             cm_ptr;
    logic [AW:0]             wr_ptr_nxt;
    logic                    accept;
    logic                    pop;

    // Pointer difference stays correct across wrap because pointers carry an extra wrap bit.
    assign count = wr_ptr - rd_ptr;
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (cm_ptr == rd_ptr);

    assign accept     = wr_en && !full;
    assign pop        = ren && !empty;
    assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, accept};

    assign packet_out = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            overflow_error  <= 1'b0;
            underflow_error <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            if (pop) begin
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (wr_en && full) begin
                overflow_error <= 1'b1;
            end
            if (ren && empty) begin
                underflow_error <= 1'b1;
            end
        end
    end

`ifdef GRID_INPUT_BUFFER_COMMIT_EN
    // Commit publishes the post-edge write pointer, so a packet written on the commit edge is included.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cm_ptr <= '0;
        end else if (commit) begin
            cm_ptr <= wr_ptr_nxt;
        end
    end
`else
    logic unused_commit;
    assign unused_commit = commit;
    assign cm_ptr        = wr_ptr;
`endif

endmodule

// File: doc/grid_input_buffer.md
# grid_input_buffer

Packet ingress FIFO that sits directly upstream of the RANC network grid. It accepts spike packets from the host/testbench side, stores them, and presents them to the west input of core 0 through the grid's `packet_in` / `input_buffer_empty` / `ren_to_input_buffer` handshake. Packets become visible to the grid only after the host commits them, so each tick's input set is delivered atomically. It also reports occupancy and sticky overflow/underflow errors.

## Interface
- `PACKET_WIDTH`, default 30: packet width; must match the grid's packet width (dx 9 + dy 9 + axon 8 + tick 4).
- `DEPTH`, default 16: number of FIFO entries; must be a power of two, ≥ 2.
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `wr_en`  input  1  host write request.
- `wr_data`  input  PACKET_WIDTH  host packet.
- `commit`  input  1  exposes all written packets to the grid.
- `full`  output  1  stored count == DEPTH.
- `ren`  input  1  pop request; connects to the grid's `ren_to_input_buffer`.
- `empty`  output  1  no committed packet available; connects to `input_buffer_empty`.
- `packet_out`  output  PACKET_WIDTH  head committed packet; connects to `packet_in`.
- `count`  output  $clog2(DEPTH)+1  total stored packets (committed + uncommitted).
- `overflow_error`  output  1  sticky: a write was attempted while full.
- `underflow_error`  output  1  sticky: a pop was attempted while empty.

## Operation
- Storage: DEPTH-entry register array. Pointers `wr_ptr`, `cm_ptr`, `rd_ptr` are each $clog2(DEPTH)+1 bits; the MSB is a wrap bit and the low bits index the array. Pointers wrap modulo 2·DEPTH.
- `count = wr_ptr − rd_ptr`; `full = (count == DEPTH)`; `empty = (cm_ptr == rd_ptr)`.
- Write: when `wr_en && !full`, the array entry at `wr_ptr` is written and `wr_ptr` increments. When `wr_en && full`, the write is dropped and `overflow_error` is set.
- Commit: when `commit` is high, `cm_ptr` takes the next value of `wr_ptr`. A packet written on the same edge is therefore included in the commit.
- Read: first-word-fall-through. `packet_out` shows the array entry at `rd_ptr` whenever `!empty`, and is forced to 0 when empty. When `ren && !empty`, `rd_ptr` increments. When `ren && empty`, there is no pointer change and `underflow_error` is set.
- `full` and `empty` are evaluated from the registered state, before the edge:
  - A simultaneous write and read while full: the write is rejected and the read proceeds.
  - A simultaneous read and write while empty: the read is an underflow.
- Error flags clear only on reset.
- No state machine beyond the pointers. Uncommitted packets are never visible to the grid and are never popped.

## Timing
- Reset values: `wr_ptr = cm_ptr = rd_ptr = 0`, `empty = 1`, `full = 0`, `count = 0`, `packet_out = 0`, both error flags 0.
- Reset is asynchronous and may occur mid-operation. All stored and uncommitted packets are discarded immediately. Array contents need not be cleared.
- Write to `count` update: 1 cycle (visible after the accepting edge).
- Commit to `empty` deassertion: 1 cycle. `packet_out` is valid in that same cycle.
- Pop to next head on `packet_out`: 1 cycle after the popping edge. Back-to-back pops every cycle are supported.
- Latency from a `wr_en` + `commit` edge to data on `packet_out`: 1 cycle.
- `full`, `empty`, `count` and `packet_out` are combinational decodes of registered pointers and the array. There is no combinational path from `wr_en`, `ren` or `commit` to any output.

## Configuration
- `GRID_INPUT_BUFFER_COMMIT_EN` defined: commit gating as described above.
- `GRID_INPUT_BUFFER_COMMIT_EN` undefined:
  - The `commit` port still exists but is ignored.
  - `cm_ptr` is identical to `wr_ptr`, so every accepted packet is visible 1 cycle after its write edge (plain FWFT FIFO).

## Test plan
- Reset, then write 3 packets (0x1, 0x2, 0x3) without commit -> `count` = 3, `empty` stays 1, `packet_out` = 0. Pop attempt -> `underflow_error` = 1.
- Write 0xA, 0xB, 0xC; `commit` on the 0xC edge; grid pops each cycle -> `empty` falls 1 cycle after the commit; `packet_out` shows 0xA, 0xB, 0xC on consecutive cycles; `empty` rises after the 3rd pop.
- Write 16 packets (DEPTH = 16) -> `full` = 1, `count` = 16. 17th write -> dropped, `overflow_error` = 1. Write + pop on the same edge while full -> `count` = 15, not 16.
- Continuous write, commit and pop for 40 packets (pointer wrap) -> output order is identical to input order; `count` never exceeds 2.
- Commit 4 packets, pop 2, assert `rst` low asynchronously between edges -> all outputs return to reset values immediately; after release, `empty` = 1 and `count` = 0.
- Build without `GRID_INPUT_BUFFER_COMMIT_EN`: write 0x5 with `commit` = 0 -> `empty` = 0 and `packet_out` = 0x5 on the next cycle.
